// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

  localparam int unsigned REG_AW_DEFAULT = 5;
  // Entry address field is sized for the widest supported register file;
  // narrower addresses are zero-extended so equality is unaffected.
  localparam int unsigned HZ_AW_MAX = 8;

  localparam int unsigned FWD_RF = 0;
  localparam int unsigned FWD_M  = 1;
  localparam int unsigned FWD_W  = 2;

  typedef struct packed {
    logic                 valid;
    logic [HZ_AW_MAX-1:0] waddr;
    logic                 reg_wr;
    logic                 is_load;
  } hz_entry_t;

  localparam hz_entry_t HZ_EMPTY = '0;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_HOLD,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_ADVANCE
  } hz_action_t;

  function automatic logic is_writer(input hz_entry_t e, input logic [HZ_AW_MAX-1:0] r);
    return e.valid && e.reg_wr && (e.waddr == r) && (r != '0);
  endfunction

endpackage

// File: rtl/pipeline_hazard_unit_match.sv
// Matches one source address against the in-flight entry array: youngest
// writer stage, whether it is a not-yet-forwardable load, and forward select.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned REG_AW     = REG_AW_DEFAULT,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned FW         = $clog2(NUM_STAGES),
  parameter int unsigned FIRST      = 1,
  parameter int unsigned OFFSET     = 0
) (
  input  logic [REG_AW-1:0]          addr,
  input  logic                       used,
  input  hz_entry_t [NUM_STAGES-1:0] ent,
  output logic [FW-1:0]              stage,
  output logic                       load_block,
  output logic [FW-1:0]              fwd_stage
);

  logic [HZ_AW_MAX-1:0] addr_ext;

  assign addr_ext = HZ_AW_MAX'(addr);

  // Scan oldest to youngest so the last hit is the youngest writer.
  // OFFSET shifts a D-stage view into the E-stage frame (the reader is one
  // stage behind E), so the same load-readiness test serves both.
  always_comb begin
    stage      = '0;
    load_block = 1'b0;
    fwd_stage  = '0;
    for (int unsigned k = NUM_STAGES; k > FIRST; k--) begin
      if (used && is_writer(ent[k-1], addr_ext)) begin
        stage      = FW'(k - 1);
        load_block = ent[k-1].is_load && ((k - 1 + OFFSET) < (1 + LOAD_LAT));
        if (!(ent[k-1].is_load && ((k - 1 + OFFSET) < (1 + LOAD_LAT))))
          fwd_stage = FW'(k - 1);
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller: forward selects, stalls, flush, E/M bubble.
// Optional HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned REG_AW     = REG_AW_DEFAULT,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned FW         = $clog2(NUM_STAGES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] raddrD,
  input  logic [NUM_SRC-1:0]        rusedD,
  input  logic [REG_AW-1:0]         waddrD,
  input  logic                      reg_wrD,
  input  logic                      is_loadD,
  input  logic                      validD,
  input  logic                      br_taken,
  input  logic                      ex_busy,
  output logic                      Stall,
  output logic                      Flush,
  output logic                      BubbleM,
  output logic [NUM_SRC*FW-1:0]     For_sel
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               flush_cnt
`endif
);

  hz_entry_t [NUM_STAGES-1:0] ent, ent_nxt;
  logic [NUM_SRC*REG_AW-1:0]  src_e, src_e_nxt;
  logic [NUM_SRC-1:0]         used_e, used_e_nxt;
  logic [NUM_SRC-1:0]         block_d;
  logic [NUM_SRC*FW-1:0]      sel_e;
  logic [NUM_SRC*FW-1:0]      unused_stage_e, unused_stage_d, unused_fwd_d;
  logic [NUM_SRC-1:0]         unused_block_e;
  logic                       ld_stall;
  hz_action_t                 act;
  hz_entry_t                  entry_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_match #(
      .NUM_STAGES(NUM_STAGES),
      .REG_AW    (REG_AW),
      .LOAD_LAT  (LOAD_LAT),
      .FW        (FW),
      .FIRST     (1),
      .OFFSET    (0)
    ) u_match_e (
      .addr      (src_e[i*REG_AW +: REG_AW]),
      .used      (used_e[i]),
      .ent       (ent),
      .stage     (unused_stage_e[i*FW +: FW]),
      .load_block(unused_block_e[i]),
      .fwd_stage (sel_e[i*FW +: FW])
    );

    hazard_match #(
      .NUM_STAGES(NUM_STAGES),
      .REG_AW    (REG_AW),
      .LOAD_LAT  (LOAD_LAT),
      .FW        (FW),
      .FIRST     (0),
      .OFFSET    (1)
    ) u_match_d (
      .addr      (raddrD[i*REG_AW +: REG_AW]),
      .used      (rusedD[i]),
      .ent       (ent),
      .stage     (unused_stage_d[i*FW +: FW]),
      .load_block(block_d[i]),
      .fwd_stage (unused_fwd_d[i*FW +: FW])
    );
  end

  assign ld_stall = |block_d;

  always_comb begin
    entry_d         = HZ_EMPTY;
    entry_d.valid   = validD;
    entry_d.waddr   = HZ_AW_MAX'(waddrD);
    entry_d.reg_wr  = reg_wrD;
    entry_d.is_load = is_loadD;
  end

  always_comb begin
    Stall   = 1'b0;
    Flush   = 1'b0;
    BubbleM = 1'b0;
    For_sel = sel_e;
    act     = ACT_ADVANCE;
    if (rst) begin
      act     = ACT_RESET;
      For_sel = '0;
    end else if (ex_busy) begin
      act     = ACT_HOLD;
      Stall   = 1'b1;
      BubbleM = 1'b1;
    end else if (br_taken) begin
      act   = ACT_FLUSH;
      Flush = 1'b1;
    end else if (ld_stall) begin
      act   = ACT_BUBBLE;
      Stall = 1'b1;
    end
  end

  always_comb begin
    ent_nxt    = ent;
    src_e_nxt  = src_e;
    used_e_nxt = used_e;
    for (int unsigned k = 1; k < NUM_STAGES; k++)
      ent_nxt[k] = ent[k-1];
    unique case (act)
      ACT_RESET: ;
      // E holds its instruction; the slot it would have vacated becomes a bubble in M.
      ACT_HOLD: begin
        ent_nxt[0] = ent[0];
        ent_nxt[1] = HZ_EMPTY;
      end
      ACT_FLUSH, ACT_BUBBLE: begin
        ent_nxt[0] = HZ_EMPTY;
        src_e_nxt  = '0;
        used_e_nxt = '0;
      end
      default: begin
        ent_nxt[0] = entry_d;
        src_e_nxt  = raddrD;
        used_e_nxt = validD ? rusedD : '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent    <= '0;
      src_e  <= '0;
      used_e <= '0;
    end else begin
      ent    <= ent_nxt;
      src_e  <= src_e_nxt;
      used_e <= used_e_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (Stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if (Flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: a vector table on the default
// configuration plus a hand sequence on a 4-stage, LOAD_LAT=2 instance.
module tb_pipeline_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [9:0] raddrD;
  logic [1:0] rusedD;
  logic [4:0] waddrD;
  logic       reg_wrD, is_loadD, validD, br_taken, ex_busy;
  logic       Stall, Flush, BubbleM;
  logic [3:0] For_sel;

  logic       rst2;
  logic [9:0] raddrD2;
  logic [1:0] rusedD2;
  logic [4:0] waddrD2;
  logic       reg_wrD2, is_loadD2, validD2, br_taken2, ex_busy2;
  logic       Stall2, Flush2, BubbleM2;
  logic [3:0] For_sel2;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, stall_cnt2, flush_cnt2;
`endif

  pipeline_hazard_unit dut (
    .clk(clk), .rst(rst), .raddrD(raddrD), .rusedD(rusedD), .waddrD(waddrD),
    .reg_wrD(reg_wrD), .is_loadD(is_loadD), .validD(validD),
    .br_taken(br_taken), .ex_busy(ex_busy),
    .Stall(Stall), .Flush(Flush), .BubbleM(BubbleM), .For_sel(For_sel)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  pipeline_hazard_unit #(.NUM_STAGES(4), .LOAD_LAT(2)) dut2 (
    .clk(clk), .rst(rst2), .raddrD(raddrD2), .rusedD(rusedD2), .waddrD(waddrD2),
    .reg_wrD(reg_wrD2), .is_loadD(is_loadD2), .validD(validD2),
    .br_taken(br_taken2), .ex_busy(ex_busy2),
    .Stall(Stall2), .Flush(Flush2), .BubbleM(BubbleM2), .For_sel(For_sel2)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
`endif
  );

  typedef struct {
    logic       rst;
    logic [4:0] ra0, ra1;
    logic [1:0] used;
    logic [4:0] wd;
    logic       wr, ld, v, br, busy;
    logic       st, fl, bb;
    logic [1:0] s0, s1;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs[NV];

  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(input int r, input int a0, input int a1, input int u,
                              input int wd, input int wr, input int ld, input int v,
                              input int br, input int busy, input int st, input int fl,
                              input int bb, input int s0, input int s1);
    vec_t x;
    x.rst = (r != 0);   x.ra0 = 5'(a0); x.ra1 = 5'(a1); x.used = 2'(u);
    x.wd = 5'(wd);      x.wr = (wr != 0); x.ld = (ld != 0); x.v = (v != 0);
    x.br = (br != 0);   x.busy = (busy != 0);
    x.st = (st != 0);   x.fl = (fl != 0); x.bb = (bb != 0);
    x.s0 = 2'(s0);      x.s1 = 2'(s1);
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step2(input string nm, input int ra0, input int wd, input int ld,
                       input int st, input int sel);
    @(negedge clk);
    rst2 = 1'b0;
    raddrD2 = {5'd0, 5'(ra0)}; rusedD2 = 2'b01; waddrD2 = 5'(wd);
    reg_wrD2 = 1'b1; is_loadD2 = (ld != 0); validD2 = 1'b1;
    #1;
    check({nm, "_stall"}, {31'd0, Stall2}, st);
    check({nm, "_sel0"}, {30'd0, For_sel2[1:0]}, sel);
  endtask

  initial begin
`ifdef HAZARD_PERF_EN
    int m_stall = 0;
    int m_flush = 0;
`endif
    rst = 1'b1; raddrD = '0; rusedD = '0; waddrD = '0; reg_wrD = 1'b0;
    is_loadD = 1'b0; validD = 1'b0; br_taken = 1'b0; ex_busy = 1'b0;
    rst2 = 1'b1; raddrD2 = '0; rusedD2 = '0; waddrD2 = '0; reg_wrD2 = 1'b0;
    is_loadD2 = 1'b0; validD2 = 1'b0; br_taken2 = 1'b0; ex_busy2 = 1'b0;

    //               r  a0 a1 u  wd wr ld v br bz | st fl bb s0 s1
    vecs[0]  = mk(1, 1, 2, 3, 5, 1, 0, 1, 1, 1,   0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 2, 3, 5, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 5, 1, 3, 6, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 10, 11, 3, 9, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    vecs[4]  = mk(0, 1, 2, 3, 7, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 3, 4, 3, 8, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 7, 0, 3, 12, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 0, 1, 7, 1, 0, 1, 0, 0,   0, 0, 0, 2, 0);
    vecs[8]  = mk(0, 2, 0, 1, 7, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 7, 7, 3, 14, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    vecs[10] = mk(0, 1, 0, 1, 0, 1, 0, 1, 0, 0,   0, 0, 0, 1, 1);
    vecs[11] = mk(0, 0, 0, 3, 16, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    vecs[12] = mk(0, 1, 0, 1, 3, 1, 1, 1, 0, 0,   0, 0, 0, 0, 0);
    vecs[13] = mk(0, 3, 2, 3, 17, 1, 0, 1, 0, 0,  1, 0, 0, 0, 0);
    vecs[14] = mk(0, 3, 2, 3, 17, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    vecs[15] = mk(0, 1, 2, 3, 18, 1, 0, 1, 0, 0,  0, 0, 0, 2, 0);
    vecs[16] = mk(0, 1, 0, 1, 4, 1, 1, 1, 0, 0,   0, 0, 0, 0, 0);
    vecs[17] = mk(0, 4, 0, 1, 1, 1, 0, 1, 1, 0,   0, 1, 0, 0, 0);
    vecs[18] = mk(0, 4, 1, 3, 20, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    vecs[19] = mk(0, 20, 6, 3, 21, 1, 0, 1, 0, 0, 0, 0, 0, 2, 0);
    vecs[20] = mk(0, 21, 1, 3, 22, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0);
    vecs[21] = mk(0, 21, 1, 3, 22, 1, 0, 1, 1, 1, 1, 0, 1, 2, 0);
    vecs[22] = mk(0, 21, 1, 3, 22, 1, 0, 1, 0, 1, 1, 0, 1, 0, 0);
    vecs[23] = mk(0, 21, 1, 3, 22, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[24] = mk(0, 1, 2, 3, 24, 1, 0, 1, 0, 0,  0, 0, 0, 1, 0);
    vecs[25] = mk(0, 1, 0, 1, 9, 1, 1, 1, 0, 0,   0, 0, 0, 0, 0);
    vecs[26] = mk(1, 9, 9, 3, 25, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    vecs[27] = mk(0, 9, 9, 3, 25, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    vecs[28] = mk(0, 1, 2, 3, 26, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; raddrD = {vecs[i].ra1, vecs[i].ra0}; rusedD = vecs[i].used;
      waddrD = vecs[i].wd; reg_wrD = vecs[i].wr; is_loadD = vecs[i].ld;
      validD = vecs[i].v; br_taken = vecs[i].br; ex_busy = vecs[i].busy;
      #1;
      check($sformatf("row%0d_stall", i), {31'd0, Stall}, {31'd0, vecs[i].st});
      check($sformatf("row%0d_flush", i), {31'd0, Flush}, {31'd0, vecs[i].fl});
      check($sformatf("row%0d_bubble", i), {31'd0, BubbleM}, {31'd0, vecs[i].bb});
      check($sformatf("row%0d_sel0", i), {30'd0, For_sel[1:0]}, {30'd0, vecs[i].s0});
      check($sformatf("row%0d_sel1", i), {30'd0, For_sel[3:2]}, {30'd0, vecs[i].s1});
`ifdef HAZARD_PERF_EN
      if (i > 0) begin
        check($sformatf("row%0d_stall_cnt", i), stall_cnt, m_stall);
        check($sformatf("row%0d_flush_cnt", i), flush_cnt, m_flush);
      end
      m_stall = vecs[i].rst ? 0 : m_stall + int'(vecs[i].st);
      m_flush = vecs[i].rst ? 0 : m_flush + int'(vecs[i].fl);
`endif
    end

    // Four stages, LOAD_LAT=2: lw x3 then a reader of x3 stalls twice and
    // then forwards from stage 3.
    @(negedge clk);
    rst2 = 1'b1; raddrD2 = {5'd0, 5'd3}; rusedD2 = 2'b01; validD2 = 1'b1;
    #1;
    check("l2_rst_stall", {31'd0, Stall2}, 0);
    step2("l2_lw",     1, 3, 1,  0, 0);
    step2("l2_use_a",  3, 10, 0, 1, 0);
    step2("l2_use_b",  3, 10, 0, 1, 0);
    step2("l2_use_go", 3, 10, 0, 0, 0);
    step2("l2_fwd",    1, 11, 0, 0, 3);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
